// File: rtl/vec_mem_pkg.sv
// Shared constants and state encoding for the memory-to-memory vector engine.
package vec_mem_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        WR,
        DONE
    } state_t;

endpackage

// File: rtl/vec_alu.sv
// Combinational element operator: add/sub wrap modulo 2^DATA_W, no flags.
module vec_alu
    import vec_mem_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [1:0]        op,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/vec_mem_engine.sv
// Vector engine driving both DMem ports: dst[i] = src1[i] OP src2[i], three cycles per element.
//
// state | meaning
// IDLE  | waiting for start, memory ports quiet
// RD    | both ports address the source operands of element idx
// CAP   | read data captured into operand registers a/b
// WR    | port A writes a OP b to dst_base + idx
// DONE  | one-cycle completion pulse, start ignored
module vec_mem_engine
    import vec_mem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] src1_base,
    input  logic [ADDR_W-1:0] src2_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [ADDR_W-1:0] len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addra,
    output logic [DATA_W-1:0] mem_dina,
    output logic              mem_wea,
    input  logic [DATA_W-1:0] mem_douta,
    output logic [ADDR_W-1:0] mem_addrb,
    output logic [DATA_W-1:0] mem_dinb,
    output logic              mem_web,
    input  logic [DATA_W-1:0] mem_doutb
);

    state_t            state;
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] src1_q;
    logic [ADDR_W-1:0] src2_q;
    logic [ADDR_W-1:0] dst_q;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W:0]   idx_nxt;
    logic              last;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] y;

    // One extra bit so idx+1 compares cleanly against len up to its maximum.
    assign idx_nxt = {1'b0, idx} + (ADDR_W+1)'(1);
    assign last    = idx_nxt >= {1'b0, len_q};

    vec_alu u_alu (
        .a  (a),
        .b  (b),
        .op (op_q),
        .y  (y)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            op_q   <= '0;
            src1_q <= '0;
            src2_q <= '0;
            dst_q  <= '0;
            len_q  <= '0;
            idx    <= '0;
            a      <= '0;
            b      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        src1_q <= src1_base;
                        src2_q <= src2_base;
                        dst_q  <= dst_base;
                        len_q  <= len;
                        idx    <= '0;
                        if (len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RD;
                            busy  <= 1'b1;
                        end
                    end
                end
                RD: begin
                    state <= CAP;
                end
                CAP: begin
                    a     <= mem_douta;
                    b     <= mem_doutb;
                    state <= WR;
                end
                WR: begin
                    idx <= idx_nxt[ADDR_W-1:0];
                    if (last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= RD;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Port decode depends only on registered state, so the write path never sees raw mem_dout*.
    always_comb begin
        mem_addra = '0;
        mem_addrb = '0;
        mem_dina  = '0;
        mem_wea   = 1'b0;
        case (state)
            RD: begin
                mem_addra = src1_q + idx;
                mem_addrb = src2_q + idx;
            end
            WR: begin
                mem_addra = dst_q + idx;
                mem_dina  = y;
                mem_wea   = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign mem_web  = 1'b0;
    assign mem_dinb = '0;

endmodule

// File: tb/tb_vec_mem_engine.sv
// Randomized self-checking bench: DMem model plus a sequential element-by-element reference.
module tb_vec_mem_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [9:0]  src1_base;
    logic [9:0]  src2_base;
    logic [9:0]  dst_base;
    logic [9:0]  len;
    logic        busy;
    logic        done;
    logic [9:0]  mem_addra;
    logic [15:0] mem_dina;
    logic        mem_wea;
    logic [15:0] mem_douta;
    logic [9:0]  mem_addrb;
    logic [15:0] mem_dinb;
    logic        mem_web;
    logic [15:0] mem_doutb;

    logic [15:0] mem     [0:1023];
    logic [15:0] ref_mem [0:1023];
    logic        poke_en = 1'b0;
    logic [9:0]  poke_addr = '0;
    logic [15:0] poke_data = '0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    vec_mem_engine dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .src1_base (src1_base),
        .src2_base (src2_base),
        .dst_base  (dst_base),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .mem_addra (mem_addra),
        .mem_dina  (mem_dina),
        .mem_wea   (mem_wea),
        .mem_douta (mem_douta),
        .mem_addrb (mem_addrb),
        .mem_dinb  (mem_dinb),
        .mem_web   (mem_web),
        .mem_doutb (mem_doutb)
    );

    // DMem: synchronous read, 1-cycle latency, port A writes; bench pokes share the same process.
    always @(posedge clk) begin
        if (poke_en)
            mem[poke_addr] <= poke_data;
        else if (mem_wea)
            mem[mem_addra] <= mem_dina;
        mem_douta <= mem[mem_addra];
        mem_doutb <= mem[mem_addrb];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
        int r;
        case (o)
            2'd0:    r = int'(x) + int'(y);
            2'd1:    r = int'(x) - int'(y);
            2'd2:    r = int'(x & y);
            default: r = int'(x | y);
        endcase
        return 16'(r);
    endfunction

    task automatic poke(input int a, input logic [15:0] v);
        @(negedge clk);
        poke_en   = 1'b1;
        poke_addr = 10'(a);
        poke_data = v;
        ref_mem[a % 1024] = v;
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    task automatic scramble_inputs();
        op        = 2'($urandom);
        src1_base = 10'($urandom);
        src2_base = 10'($urandom);
        dst_base  = 10'($urandom);
        len       = 10'($urandom_range(1, 1023));
    endtask

    task automatic compare_mem(input string tag);
        int mism = 0;
        for (int k = 0; k < 1024; k++)
            if (mem[k] !== ref_mem[k]) mism++;
        chk(tag, 32'(mism), 32'd0);
    endtask

    // rst_cyc > 0 asserts reset during that cycle; pulse_done raises start while the engine is in DONE.
    task automatic run_vec(input string tag, input logic [1:0] o, input int s1, input int s2,
                           input int d, input int n, input int rst_cyc, input bit pulse_done);
        int busy_cnt = 0, done_cnt = 0, done_cyc = 0, first_busy = 0, wea_cnt = 0, portb_bad = 0;
        int n_wr = n;
        int limit = 3 * n + 4;
        if (rst_cyc > 0) begin
            n_wr = 0;
            for (int i = 0; i < n; i++)
                if (3 * i + 3 <= rst_cyc) n_wr++;
            limit = rst_cyc + 1;
        end
        for (int i = 0; i < n_wr; i++)
            ref_mem[(d + i) % 1024] = ref_op(o, ref_mem[(s1 + i) % 1024], ref_mem[(s2 + i) % 1024]);

        @(negedge clk);
        op        = o;
        src1_base = 10'(s1);
        src2_base = 10'(s2);
        dst_base  = 10'(d);
        len       = 10'(n);
        start     = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            if (rst_cyc > 0 && c == rst_cyc + 1) begin
                chk({tag, "_rst_busy"}, 32'(busy), 32'd0);
                chk({tag, "_rst_done"}, 32'(done), 32'd0);
                chk({tag, "_rst_wea"}, 32'(mem_wea), 32'd0);
                chk({tag, "_rst_addra"}, 32'(mem_addra), 32'd0);
                chk({tag, "_rst_dina"}, 32'(mem_dina), 32'd0);
                reset = 1'b0;
                break;
            end
            if (busy) begin
                busy_cnt++;
                if (first_busy == 0) first_busy = c;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (mem_wea) wea_cnt++;
            if (mem_web !== 1'b0 || mem_dinb !== 16'h0) portb_bad++;
            if (c == 1) begin
                scramble_inputs();
                start = pulse_done;
            end else begin
                start = 1'b0;
            end
            if (rst_cyc > 0 && c == rst_cyc) reset = 1'b1;
        end
        start = 1'b0;
        chk({tag, "_portb"}, 32'(portb_bad), 32'd0);
        chk({tag, "_writes"}, 32'(wea_cnt), 32'(n_wr));
        if (rst_cyc == 0) begin
            chk({tag, "_done_cyc"}, 32'(done_cyc), 32'(3 * n + 1));
            chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
            chk({tag, "_busy_cnt"}, 32'(busy_cnt), 32'(3 * n));
            chk({tag, "_busy_first"}, 32'(first_busy), (n == 0) ? 32'd0 : 32'd1);
        end
        compare_mem({tag, "_mem"});
    endtask

    initial begin
        int s1, s2, d, n;
        logic [1:0] o;
        reset = 1'b1;
        start = 1'b0;
        scramble_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wea", 32'(mem_wea), 32'd0);
        chk("rst_web", 32'(mem_web), 32'd0);
        chk("rst_addra", 32'(mem_addra), 32'd0);
        chk("rst_addrb", 32'(mem_addrb), 32'd0);
        chk("rst_dina", 32'(mem_dina), 32'd0);
        chk("rst_dinb", 32'(mem_dinb), 32'd0);
        reset = 1'b0;

        for (int k = 0; k < 1024; k++)
            poke(k, 16'($urandom));

        poke(12'h010, 16'd1);  poke(12'h011, 16'd2);  poke(12'h012, 16'd3);  poke(12'h013, 16'hFFFF);
        poke(12'h020, 16'd10); poke(12'h021, 16'd20); poke(12'h022, 16'd30); poke(12'h023, 16'd1);
        run_vec("add4", 2'd0, 12'h010, 12'h020, 12'h030, 4, 0, 1'b0);
        chk("add4_e0", 32'(mem[10'h030]), 32'd11);
        chk("add4_e1", 32'(mem[10'h031]), 32'd22);
        chk("add4_e2", 32'(mem[10'h032]), 32'd33);
        chk("add4_e3", 32'(mem[10'h033]), 32'h0000);

        poke(12'h100, 16'd5); poke(12'h101, 16'd0);
        poke(12'h200, 16'd7); poke(12'h201, 16'd1);
        run_vec("sub_inpl", 2'd1, 12'h100, 12'h200, 12'h100, 2, 0, 1'b0);
        chk("sub_e0", 32'(mem[10'h100]), 32'hFFFE);
        chk("sub_e1", 32'(mem[10'h101]), 32'hFFFF);
        chk("sub_src2_0", 32'(mem[10'h200]), 32'd7);
        chk("sub_src2_1", 32'(mem[10'h201]), 32'd1);

        poke(12'h3FE, 16'h0F0F); poke(12'h3FF, 16'h00FF); poke(12'h000, 16'hFFFF);
        run_vec("wrap_and", 2'd2, 12'h3FE, 12'h000, 12'h3FF, 3, 0, 1'b0);

        run_vec("len0", 2'd0, 12'h050, 12'h060, 12'h070, 0, 0, 1'b1);
        @(negedge clk);
        chk("len0_ignored_busy", 32'(busy), 32'd0);
        chk("len0_ignored_done", 32'(done), 32'd0);

        run_vec("rst_or", 2'd3, 12'h080, 12'h090, 12'h0A0, 5, 5, 1'b0);
        run_vec("after_rst", 2'd3, 12'h080, 12'h090, 12'h0A0, 5, 0, 1'b0);

        for (int t = 0; t < 12; t++) begin
            o  = 2'($urandom_range(0, 3));
            s1 = int'($urandom_range(0, 1023));
            s2 = int'($urandom_range(0, 1023));
            d  = (t % 3 == 0) ? (s1 + 1) % 1024 : int'($urandom_range(0, 1023));
            n  = int'($urandom_range(1, 24));
            run_vec($sformatf("rand%0d", t), o, s1, s2, d, n, 0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vec_mem_engine.md
# vec_mem_engine

Memory-to-memory vector execution engine that is the initiator side of the dual-port `DMem` block RAM (1024 x 16, synchronous read, 1-cycle latency). It performs `dst[i] = src1[i] OP src2[i]` for `i = 0..len-1`. Port A and port B fetch one operand each; port A then writes the result. It sits between the vector control unit, which issues start/operands, and `DMem`, whose ports it drives exclusively while busy.

## Interface
Parameters:
- `ADDR_W`, 10, DMem word-address width
- `DATA_W`, 16, element width

Ports:
- `clk` in 1: single clock; both DMem ports run on it
- `reset` in 1: synchronous, active-high
- `start` in 1: request; sampled only in IDLE
- `op` in 2: 00 add, 01 sub (src1-src2), 10 and, 11 or
- `src1_base`, `src2_base`, `dst_base` in ADDR_W: element-0 addresses
- `len` in ADDR_W: element count, 0..1023
- `busy` out 1: high from the cycle after start is accepted until the last write
- `done` out 1: one-cycle completion pulse
- `mem_addra` out ADDR_W, `mem_dina` out DATA_W, `mem_wea` out 1, `mem_douta` in DATA_W
- `mem_addrb` out ADDR_W, `mem_dinb` out DATA_W, `mem_web` out 1, `mem_doutb` in DATA_W

## Operation
- States: IDLE, RD, CAP, WR, DONE.
- IDLE + `start`:
  - latch `op`, the three bases and `len`; clear index `i`
  - next state is RD, or DONE if `len == 0`
- RD:
  - `mem_addra = src1_base + i`, `mem_addrb = src2_base + i`
  - `mem_wea = mem_web = 0`
  - next state CAP
- CAP:
  - register `mem_douta`/`mem_doutb` into operand regs `a`, `b`
  - no write; next state WR
- WR:
  - `mem_addra = dst_base + i`, `mem_dina = a OP b`, `mem_wea = 1`
  - `i++`; next state RD if `i+1 < len`, else DONE
- DONE: `done = 1` for one cycle, then IDLE. `start` is ignored in DONE.
- Arithmetic: add/sub modulo 2^16, no flags. Address sums are modulo 2^ADDR_W, so wrap 1023 -> 0 is legal.
- Overlap: the write of element i commits before the read of element i+1.
  - In-place (`dst == src1` or `dst == src2`) is correct.
  - Forward-overlapping ranges see already-written results; this is defined behaviour, not an error.
- Port B never writes: `mem_web = 0` and `mem_dinb = 0` always.
- Latched operands are immune to input changes while busy.
- `reset` in any state:
  - next state IDLE
  - outputs take reset values from the following cycle
  - a write in progress in the reset cycle is not suppressed retroactively
  - no further writes are issued

## Timing
- Reset values: `busy = 0`, `done = 0`, `mem_wea = 0`, `mem_web = 0`, all `mem_addr*` and `mem_din*` = 0.
- Outside WR, `mem_dina = 0` and `mem_wea = 0`.
- Start accepted at edge E0. Element i is in RD during cycle `3i+1`, CAP during `3i+2`, WR during `3i+3`. Cycles are counted after E0.
- `busy` is high for cycles 1..3·len. `done` is high in cycle `3·len+1`. IDLE resumes in cycle `3·len+2`, where a new start may be accepted.
- `len = 0`: `busy` never rises; `done` fires in cycle 1; no memory access.
- Memory outputs are decoded from registered state and index. Data into the write path comes from CAP registers, never directly from `mem_dout*`.

## Structure
- Package `vec_mem_pkg` holds:
  - `ADDR_W`, `DATA_W`
  - op-code constants `OP_ADD`, `OP_SUB`, `OP_AND`, `OP_OR`
  - state enumeration
- Sub-module `vec_alu`: combinational 16-bit op unit (`a`, `b`, `op` -> `y`), instantiated once.

## Test plan
- Add, len=4, src1=0x010 (1,2,3,0xFFFF), src2=0x020 (10,20,30,1), dst=0x030 -> DMem[0x030..0x033] = 11, 22, 33, 0x0000; `done` in cycle 13; `busy` high for exactly 12 cycles.
- Sub, in-place, len=2, src1=dst=0x100 (5,0), src2=0x200 (7,1) -> DMem[0x100] = 0xFFFE, DMem[0x101] = 0xFFFF; src2 unchanged.
- Wrap-around: and, len=3, src1=0x3FE, src2=0x000 (0x0F0F,0x00FF,0xFFFF), dst=0x3FF -> reads 0x3FE, 0x3FF, 0x000; writes land at 0x3FF, 0x000, 0x001, with later reads using earlier results where ranges alias; checked against a golden model.
- len=0 with `start` -> `done` in cycle 1; `mem_wea` never asserted; `start` pulsed in DONE is ignored.
- Reset asserted in CAP of element 1 of a len=5 or-op -> only element 0 written; `busy`, `done`, `mem_wea` = 0 from the next cycle; a fresh start afterwards completes normally.
